// File: rtl/ncc_peak_tracker.sv
// ncc_peak_tracker: sums 16 PE row outputs per search position and tracks the best-scoring (x, y) over a raster scan
module ncc_peak_tracker #(
    parameter int WIN_W = 25,
    parameter int WIN_H = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               score_valid,
    input  logic [15:0][7:0]   acc_row,
    output logic               busy,
    output logic               done,
    output logic signed [11:0] best_score,
    output logic [7:0]         best_x,
    output logic [7:0]         best_y,
    output logic               err
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [7:0] X_LAST = 8'(WIN_W - 1);
    localparam logic [7:0] Y_LAST = 8'(WIN_H - 1);

    state_t             state_q, state_d;
    logic               drain_q, drain_d;
    logic [7:0]         x_q, x_d, y_q, y_d;
    logic               err_q, err_d;
    logic signed [9:0]  grp_d [4];
    logic signed [9:0]  grp_q [4];
    logic               s1_v_q, s2_v_q;
    logic [7:0]         s1_x_q, s1_y_q, s2_x_q, s2_y_q;
    logic signed [11:0] tot_d, tot_q;
    logic signed [11:0] best_q, best_d;
    logic [7:0]         bx_q, bx_d, by_q, by_d;
    logic               accept, go;

    assign accept = (state_q == SCAN) && score_valid;
    assign go     = start && (state_q == IDLE || state_q == DONE);

    // Stage 1 and 2 adders: four 4-row group sums, then the 12-bit total
    always_comb begin
        for (int g = 0; g < 4; g++)
            grp_d[g] = 10'($signed(acc_row[4*g])) + 10'($signed(acc_row[4*g+1]))
                     + 10'($signed(acc_row[4*g+2])) + 10'($signed(acc_row[4*g+3]));
        tot_d = 12'(grp_q[0]) + 12'(grp_q[1]) + 12'(grp_q[2]) + 12'(grp_q[3]);
    end

    // Scan FSM, raster counters and sticky error
    always_comb begin
        state_d = state_q;
        drain_d = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = go ? 1'b0 : err_q;
        case (state_q)
            IDLE:  state_d = go ? SCAN : IDLE;
            SCAN: begin
                if (accept) begin
                    x_d = (x_q == X_LAST) ? 8'd0 : x_q + 8'd1;
                    y_d = (x_q == X_LAST) ? y_q + 8'd1 : y_q;
                    state_d = (x_q == X_LAST && y_q == Y_LAST) ? DRAIN : SCAN;
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                state_d = drain_q ? DONE : DRAIN;
            end
            DONE:  state_d = go ? SCAN : DONE;
            default: state_d = IDLE;
        endcase
        if (go) begin
            x_d = 8'd0;
            y_d = 8'd0;
        end
        if (score_valid && state_q != SCAN) err_d = 1'b1;
    end

    // Stage 3: strictly-greater replaces, so ties keep the earlier raster position
    always_comb begin
        best_d = best_q;
        bx_d   = bx_q;
        by_d   = by_q;
        if (go) begin
            best_d = -12'sd2048;
            bx_d   = 8'd0;
            by_d   = 8'd0;
        end else if (s2_v_q && tot_q > best_q) begin
            best_d = tot_q;
            bx_d   = s2_x_q;
            by_d   = s2_y_q;
        end
    end

    // Control and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            drain_q <= 1'b0;
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            err_q   <= 1'b0;
            best_q  <= 12'sd0;
            bx_q    <= 8'd0;
            by_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            x_q     <= x_d;
            y_q     <= y_d;
            err_q   <= err_d;
            best_q  <= best_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
        end
    end

    // Pipeline registers carrying partial sums tagged with their position
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s1_x_q <= 8'd0;
            s1_y_q <= 8'd0;
            s2_x_q <= 8'd0;
            s2_y_q <= 8'd0;
            tot_q  <= 12'sd0;
            for (int g = 0; g < 4; g++) grp_q[g] <= 10'sd0;
        end else begin
            s1_v_q <= accept;
            s1_x_q <= x_q;
            s1_y_q <= y_q;
            for (int g = 0; g < 4; g++) grp_q[g] <= grp_d[g];
            s2_v_q <= s1_v_q;
            s2_x_q <= s1_x_q;
            s2_y_q <= s1_y_q;
            tot_q  <= tot_d;
        end
    end

    assign busy       = (state_q == SCAN) || (state_q == DRAIN);
    assign done       = (state_q == DONE);
    assign best_score = best_q;
    assign best_x     = bx_q;
    assign best_y     = by_q;
    assign err        = err_q;
endmodule

// File: tb/tb_ncc_peak_tracker.sv
// tb_ncc_peak_tracker: randomized scans of a 3x2 window checked against a raster max-search model
module tb_ncc_peak_tracker;
    localparam int W  = 3;
    localparam int H  = 2;
    localparam int NP = W * H;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               score_valid = 1'b0;
    logic [15:0][7:0]   acc_row = '0;
    logic               busy, done, err;
    logic signed [11:0] best_score;
    logic [7:0]         best_x, best_y;

    ncc_peak_tracker #(.WIN_W(W), .WIN_H(H)) dut (
        .clk(clk), .rst(rst), .start(start), .score_valid(score_valid), .acc_row(acc_row),
        .busy(busy), .done(done), .best_score(best_score), .best_x(best_x), .best_y(best_y), .err(err)
    );

    always #5 clk = ~clk;

    logic [15:0][7:0] rows [NP];
    int n_chk = 0, n_err = 0;
    int cyc = 0, n_acc = 0;
    int acc_cyc [NP];
    bit track = 0;
    bit exp_err = 0;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int total(input int p);
        int s = 0;
        for (int r = 0; r < 16; r++) s += int'($signed(rows[p][r]));
        return s;
    endfunction

    // best over samples accepted at least two edges before 'now', scanned in raster order
    task automatic ref_best(input int now, output int s, output int bx, output int by);
        s = -2048; bx = 0; by = 0;
        for (int p = 0; p < n_acc; p++)
            if (acc_cyc[p] + 2 <= now && total(p) > s) begin
                s = total(p); bx = p % W; by = p / W;
            end
    endtask

    task automatic tick();
        int s, bx, by;
        @(negedge clk);
        cyc++;
        if (track) begin
            ref_best(cyc, s, bx, by);
            check("pipe_score", 32'($signed(best_score)), s);
            check("pipe_x", 32'(best_x), bx);
            check("pipe_y", 32'(best_y), by);
        end
    endtask

    task automatic fill(input int v);
        for (int p = 0; p < NP; p++)
            for (int r = 0; r < 16; r++) rows[p][r] = 8'(v);
    endtask

    task automatic randomize_rows(input int lo, input int hi);
        for (int p = 0; p < NP; p++)
            for (int r = 0; r < 16; r++) rows[p][r] = 8'(int'($urandom_range(hi - lo)) + lo);
    endtask

    task automatic begin_scan(input bit sv_with_start);
        track = 0;
        n_acc = 0;
        start = 1'b1;
        score_valid = sv_with_start;
        acc_row = {16{8'h7f}};
        tick();
        start = 1'b0;
        score_valid = 1'b0;
        exp_err = sv_with_start;
        track = 1;
        check("start_busy", 32'(busy), 1);
        check("start_done", 32'(done), 0);
        check("start_err", 32'(err), 32'(exp_err));
        check("start_score", 32'($signed(best_score)), -2048);
    endtask

    task automatic feed(input int gap_max, input bit mid_start, input bit drain_err, input int nmax);
        int s, bx, by;
        for (int p = 0; p < nmax; p++) begin
            repeat ($urandom_range(gap_max)) tick();
            score_valid = 1'b1;
            acc_row = rows[p];
            start = mid_start && (p == 3);
            tick();
            acc_cyc[p] = cyc;
            n_acc = p + 1;
            score_valid = 1'b0;
            start = 1'b0;
        end
        if (nmax == NP) begin
            check("drain0_busy", 32'(busy), 1);
            check("drain0_done", 32'(done), 0);
            if (drain_err) begin
                score_valid = 1'b1;
                acc_row = {16{8'h7f}};
                exp_err = 1;
            end
            tick();
            score_valid = 1'b0;
            check("drain1_busy", 32'(busy), 1);
            check("drain1_done", 32'(done), 0);
            check("drain1_err", 32'(err), 32'(exp_err));
            tick();
            check("done_busy", 32'(busy), 0);
            check("done_done", 32'(done), 1);
            check("done_err", 32'(err), 32'(exp_err));
            ref_best(1 << 30, s, bx, by);
            check("final_score", 32'($signed(best_score)), s);
            check("final_x", 32'(best_x), bx);
            check("final_y", 32'(best_y), by);
            repeat (3) tick();
            check("hold_done", 32'(done), 1);
        end
    endtask

    task automatic expect_final(input string tag, input int s, input int bx, input int by);
        check({tag, "_score"}, 32'($signed(best_score)), s);
        check({tag, "_x"}, 32'(best_x), bx);
        check({tag, "_y"}, 32'(best_y), by);
    endtask

    task automatic expect_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_score"}, 32'($signed(best_score)), 0);
        check({tag, "_x"}, 32'(best_x), 0);
        check({tag, "_y"}, 32'(best_y), 0);
    endtask

    initial begin
        int s1, x1, y1;
        #1 expect_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        tick();

        score_valid = 1'b1;
        acc_row = {16{8'h7f}};
        tick();
        score_valid = 1'b0;
        check("idle_valid_err", 32'(err), 1);
        check("idle_valid_score", 32'($signed(best_score)), 0);
        check("idle_valid_busy", 32'(busy), 0);

        fill(1);
        for (int r = 0; r < 16; r++) rows[2][r] = 8'd5;
        begin_scan(0);
        feed(0, 0, 0, NP);
        expect_final("peak", 80, 2, 0);

        fill(-128);
        for (int r = 0; r < 16; r++) rows[3][r] = 8'hff;
        begin_scan(0);
        feed(0, 0, 0, NP);
        expect_final("neg", -16, 0, 1);

        fill(0);
        rows[1][0] = 8'd40;
        rows[5][7] = 8'd40;
        begin_scan(0);
        feed(0, 0, 0, NP);
        expect_final("tie", 40, 1, 0);

        fill(-128);
        begin_scan(0);
        feed(0, 0, 0, NP);
        expect_final("floor", -2048, 0, 0);

        randomize_rows(-128, 127);
        begin_scan(0);
        feed(0, 1, 1, NP);
        s1 = best_score; x1 = best_x; y1 = best_y;
        check("proto_err", 32'(err), 1);
        begin_scan(0);
        check("start_clears_err", 32'(err), 0);
        feed(4, 0, 0, NP);
        expect_final("proto_vs_gapped", s1, x1, y1);

        for (int k = 0; k < 8; k++) begin
            randomize_rows(k[0] ? -4 : -128, k[0] ? 4 : 127);
            begin_scan(k[1]);
            feed(k[2] ? 3 : 0, k[1], k[0], NP);
        end

        randomize_rows(-128, 127);
        begin_scan(0);
        feed(0, 0, 0, 3);
        track = 0;
        rst = 1'b0;
        #1 expect_reset_outputs("midreset");
        tick();
        rst = 1'b1;
        tick();
        expect_reset_outputs("after_release");
        begin_scan(0);
        feed(2, 0, 0, NP);

        track = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
